// File: rtl/tq_trans_pkg.sv
// Shared constants, transform-size encodings and the rows-per-block lookup
// for the transpose memory datapath.
package tq_trans_pkg;

  localparam int LANES     = 32;  // lanes per row and number of banks
  localparam int ADDR_W    = 5;   // bank address / lane-select index width
  localparam int COEF_W    = 16;  // coefficient width per lane
  localparam int DEPTH     = 32;  // entries per bank
  localparam int BYP_LANES = 16;  // lanes carried by the 4x4 bypass

  typedef enum logic [1:0] {
    SIZE_4  = 2'd0,
    SIZE_8  = 2'd1,
    SIZE_16 = 2'd2,
    SIZE_32 = 2'd3
  } tsize_e;

  // Output rows that make up one block of the given size.
  function automatic logic [5:0] rows_of(input tsize_e size);
    case (size)
      SIZE_4:  rows_of = 6'd1;
      SIZE_8:  rows_of = 6'd2;
      SIZE_16: rows_of = 6'd8;
      default: rows_of = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/tq_trans_bank.sv
// One transpose bank: DEPTH x W single-port RAM with a registered read.
// Contents are not reset.
//   clk     : clock
//   we_i    : write enable (addr_i <= wdata_i)
//   re_i    : read enable (rdata_o <= mem[addr_i] on the same edge)
//   addr_i  : entry address
//   wdata_i : write data
//   rdata_o : registered read data, valid the cycle after re_i
module tq_trans_bank #(
  parameter int DEPTH = 32,
  parameter int W     = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [0:DEPTH-1];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tq_trans_mem.sv
// Transpose memory between the row and column 1-D transforms.
// Rows are written lane-permuted into LANES banks and read back as
// lane-rotated columns; 4x4 blocks take a register bypass with the same
// 2-cycle latency as a RAM read.
//
// Optional build macro TQ_TRANS_OVF_CHK_EN: when defined, a sticky overrun
// detector drives o_ovf; otherwise o_ovf is tied low. Overrun writes are
// dropped in both builds.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_valid       : input row valid
//   i_transize    : 0=4x4, 1=8x8, 2=16x16, 3=32x32
//   i_data        : input row, lane n at [n*COEF_W +: COEF_W]
//   i_rd_wr_ctl   : 0=write phase, 1=read phase
//   i_add         : per-bank address, bank j at [j*5 +: 5]
//   i_badd        : per-lane select index, entry j at [j*5 +: 5]
//   o_valid       : transposed row valid
//   o_last        : last row of block, with o_valid
//   o_data        : transposed row (held while o_valid=0)
//   o_ovf         : sticky overrun flag
module tq_trans_mem #(
  parameter int COEF_W = tq_trans_pkg::COEF_W,
  parameter int LANES  = tq_trans_pkg::LANES,
  parameter int DEPTH  = tq_trans_pkg::DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_valid,
  input  logic [1:0]                             i_transize,
  input  logic [LANES*COEF_W-1:0]                i_data,
  input  logic                                   i_rd_wr_ctl,
  input  logic [LANES*tq_trans_pkg::ADDR_W-1:0]  i_add,
  input  logic [LANES*tq_trans_pkg::ADDR_W-1:0]  i_badd,
  output logic                                   o_valid,
  output logic                                   o_last,
  output logic [LANES*COEF_W-1:0]                o_data,
  output logic                                   o_ovf
);

  import tq_trans_pkg::*;

  typedef logic [LANES-1:0][COEF_W-1:0] row_t;
  typedef logic [LANES-1:0][ADDR_W-1:0] idx_t;

  row_t din, ram_q, rd_xbar, byp_d, byp_q, data_q, data_d;
  idx_t add, badd;

  assign din  = i_data;
  assign add  = i_add;
  assign badd = i_badd;

  tsize_e size_in, size_q;
  assign size_in = tsize_e'(i_transize);

  logic ram_sel, wr_en, rd_en, byp_en, size_chg;

  // 4x4 never touches the RAM, so a size-0 row wins over a read request.
  assign ram_sel  = (size_in != SIZE_4);
  assign wr_en    = i_valid & ~i_rd_wr_ctl & ram_sel;
  assign rd_en    = i_rd_wr_ctl & ram_sel;
  assign byp_en   = i_valid & ~ram_sel;
  assign size_chg = (size_in != size_q);

  // Banks plus both lane crossbars. The read crossbar uses the i_badd of the
  // cycle in which ram_q is valid; the controller supplies it pre-aligned.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tq_trans_bank #(.DEPTH(DEPTH), .W(COEF_W), .AW(ADDR_W)) u_bank (
      .clk     (clk),
      .we_i    (wr_en),
      .re_i    (rd_en),
      .addr_i  (add[g]),
      .wdata_i (din[badd[g]]),
      .rdata_o (ram_q[g])
    );
    assign rd_xbar[g] = ram_q[badd[g]];
    if (g < BYP_LANES) begin : g_byp
      assign byp_d[g] = din[badd[g]];
    end else begin : g_zero
      assign byp_d[g] = '0;
    end
  end

  // vld_q[1]: RAM output / bypass stage 1 holds a row; vld_q[2]: o_valid.
  logic [2:1]        vld_q, vld_d;
  logic              s1_byp_q;
  logic              last_q, last_d, hit_last;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    vld_d[1] = rd_en | byp_en;
    // A size change kills whatever is in flight from the old size.
    vld_d[2] = vld_q[1] & ~size_chg;
    hit_last = ({1'b0, cnt_q} == rows_of(size_q) - 6'd1);
    data_d   = data_q;
    last_d   = 1'b0;
    cnt_d    = cnt_q;
    if (size_chg) begin
      cnt_d = '0;
    end else if (vld_d[2]) begin
      data_d = s1_byp_q ? byp_q : rd_xbar;
      last_d = hit_last;
      cnt_d  = hit_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      s1_byp_q <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      size_q   <= SIZE_4;
    end else begin
      vld_q    <= vld_d;
      s1_byp_q <= byp_en;
      data_q   <= data_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      size_q   <= size_in;
    end
  end

  // Bypass stage-1 data needs no reset: it is only consumed behind vld_q[1].
  always_ff @(posedge clk) begin
    if (byp_en) byp_q <= byp_d;
  end

`ifdef TQ_TRANS_OVF_CHK_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ovf_q <= 1'b0;
    else if (i_valid & rd_en) ovf_q <= 1'b1;
  end
  assign o_ovf = ovf_q;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_valid = vld_q[2];
  assign o_last  = last_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_tq_trans_mem.sv
// Directed bench for tq_trans_mem. Addressing model: for a block of M rows,
// row r writes bank j (j<M) at address r with lane (j-r) mod M; output row c
// reads bank j at (j-c) mod M and selects lane k from bank (c+k) mod M.
// Banks/lanes >= M carry lane j of zero data, so those output lanes are 0.
module tb_tq_trans_mem;

  localparam int L  = 32;
  localparam int CW = 16;
  localparam int AW = 5;

`ifdef TQ_TRANS_OVF_CHK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  typedef logic [L-1:0][CW-1:0] row_t;
  typedef logic [L-1:0][AW-1:0] idx_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_rd_wr_ctl;
  logic [1:0]    i_transize;
  logic [L*CW-1:0] i_data, o_data;
  logic [L*AW-1:0] i_add, i_badd;
  logic          o_valid, o_last, o_ovf;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tq_trans_mem dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_transize(i_transize),
    .i_data(i_data), .i_rd_wr_ctl(i_rd_wr_ctl), .i_add(i_add), .i_badd(i_badd),
    .o_valid(o_valid), .o_last(o_last), .o_data(o_data), .o_ovf(o_ovf)
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input row_t obs, input row_t exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rows(input int s);
    case (s)
      0:       return 1;
      1:       return 2;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int md(input int a, input int m);
    return ((a % m) + m) % m;
  endfunction

  function automatic row_t wr_data(input int s, input int base, input int r);
    row_t v;
    v = '0;
    for (int c = 0; c < rows(s); c++) v[c] = CW'(base + (4 << s) * r + c);
    return v;
  endfunction

  function automatic idx_t wr_add(input int r);
    idx_t v;
    for (int j = 0; j < L; j++) v[j] = AW'(r);
    return v;
  endfunction

  function automatic idx_t wr_badd(input int s, input int r);
    idx_t v;
    for (int j = 0; j < L; j++) v[j] = (j < rows(s)) ? AW'(md(j - r, rows(s))) : AW'(j);
    return v;
  endfunction

  function automatic idx_t rd_add(input int s, input int c);
    idx_t v;
    for (int j = 0; j < L; j++) v[j] = (j < rows(s)) ? AW'(md(j - c, rows(s))) : AW'(0);
    return v;
  endfunction

  function automatic idx_t rd_badd(input int s, input int c);
    idx_t v;
    for (int k = 0; k < L; k++) v[k] = (k < rows(s)) ? AW'(md(c + k, rows(s))) : AW'(k);
    return v;
  endfunction

  function automatic row_t exp_row(input int s, input int base, input int c);
    row_t v;
    v = '0;
    for (int k = 0; k < rows(s); k++) v[k] = CW'(base + (4 << s) * k + c);
    return v;
  endfunction

  // 4x4 bypass vectors: pattern 0 is a 4x4 transpose, pattern 1 a rotation.
  function automatic idx_t byp_badd(input int p);
    idx_t v;
    for (int k = 0; k < L; k++)
      if (k >= 16)     v[k] = AW'(k - 16);
      else if (p == 0) v[k] = AW'((k % 4) * 4 + k / 4);
      else             v[k] = AW'((k + 5) % 16);
    return v;
  endfunction

  function automatic row_t byp_data(input int p);
    row_t v;
    for (int k = 0; k < L; k++) v[k] = (k < 16) ? CW'(16 * p + k) : CW'(16'h00F0 + k);
    return v;
  endfunction

  function automatic row_t byp_exp(input int p);
    row_t v;
    idx_t b;
    v = '0;
    b = byp_badd(p);
    for (int k = 0; k < 16; k++) v[k] = CW'(16 * p + int'(b[k]));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_block(input int s, input int base);
    for (int r = 0; r < rows(s); r++) begin
      i_transize  = 2'(s);
      i_valid     = 1'b1;
      i_rd_wr_ctl = 1'b0;
      i_data      = wr_data(s, base, r);
      i_add       = wr_add(r);
      i_badd      = wr_badd(s, r);
      tick();
    end
    i_valid = 1'b0;
  endtask

  // Issues n reads; i_badd trails i_add by one cycle to line up with ram_q.
  // Beat i-1 is visible after the i-th edge. With drain=0 the bench stops
  // while reads are still in flight.
  task automatic read_block(input int s, input int base, input int n,
                            input bit drain, input bit ovr, input string tag);
    int last_i;
    last_i = drain ? n : n - 1;
    for (int i = 0; i <= last_i; i++) begin
      i_transize  = 2'(s);
      i_rd_wr_ctl = (i < n);
      i_add       = (i < n) ? rd_add(s, i) : '0;
      if (i > 0) i_badd = rd_badd(s, i - 1);
      i_valid     = ovr && (i < n);
      if (ovr) i_data = {L{16'hDEAD}};
      tick();
      if (i == 0) begin
        chk_b({tag, ".lat1"}, o_valid, 1'b0);
      end else begin
        chk_b({tag, ".vld"}, o_valid, 1'b1);
        chk_b({tag, ".last"}, o_last, (i - 1 == rows(s) - 1));
        chk_r({tag, ".data"}, o_data, exp_row(s, base, i - 1));
      end
    end
    if (drain) begin
      i_rd_wr_ctl = 1'b0;
      i_valid     = 1'b0;
      tick();
      chk_b({tag, ".idle"}, o_valid, 1'b0);
      chk_r({tag, ".hold"}, o_data, exp_row(s, base, n - 1));
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_rd_wr_ctl = 1'b0; i_transize = 2'd0;
    i_data = '0; i_add = '0; i_badd = '0;
    repeat (2) @(negedge clk);
    chk_b("rst.valid", o_valid, 1'b0);
    chk_b("rst.last", o_last, 1'b0);
    chk_r("rst.data", o_data, '0);
    chk_b("rst.ovf", o_ovf, 1'b0);
    rst = 1'b0;
    tick();

    // 8x8 identity, then 32x32 ramp
    write_block(1, 0);
    read_block(1, 0, 2, 1'b1, 1'b0, "t8");
    write_block(3, 0);
    read_block(3, 0, 32, 1'b1, 1'b0, "t32");

    // 4x4 bypass, second beat also raises read (bypass must win)
    i_transize = 2'd0; i_valid = 1'b1; i_rd_wr_ctl = 1'b0;
    i_data = byp_data(0); i_badd = byp_badd(0); i_add = '0;
    tick();
    chk_b("b4.lat1", o_valid, 1'b0);
    i_data = byp_data(1); i_badd = byp_badd(1); i_rd_wr_ctl = 1'b1;
    tick();
    chk_b("b4.vld0", o_valid, 1'b1);
    chk_b("b4.last0", o_last, 1'b1);
    chk_r("b4.data0", o_data, byp_exp(0));
    i_valid = 1'b0; i_rd_wr_ctl = 1'b0;
    tick();
    chk_b("b4.vld1", o_valid, 1'b1);
    chk_b("b4.last1", o_last, 1'b1);
    chk_r("b4.data1", o_data, byp_exp(1));
    chk_b("b4.ovf", o_ovf, 1'b0);
    tick();
    chk_b("b4.idle", o_valid, 1'b0);

    // Overrun during 16x16 read, then re-read the untouched RAM
    write_block(2, 'h100);
    read_block(2, 'h100, 8, 1'b1, 1'b1, "ovr");
    chk_b("ovr.flag", o_ovf, OVF_EXP);
    read_block(2, 'h100, 8, 1'b1, 1'b0, "ovr.reread");
    chk_b("ovr.sticky", o_ovf, OVF_EXP);

    // Size change with a 16x16 read still in flight
    write_block(2, 'h200);
    read_block(2, 'h200, 3, 1'b0, 1'b0, "chg16");
    i_transize = 2'd1; i_rd_wr_ctl = 1'b0; i_valid = 1'b0; i_badd = rd_badd(2, 2);
    tick();
    chk_b("chg.flush", o_valid, 1'b0);
    tick();
    chk_b("chg.quiet", o_valid, 1'b0);
    write_block(1, 'h300);
    read_block(1, 'h300, 2, 1'b1, 1'b0, "chg8");

    // Reset in the middle of a 32x32 read
    write_block(3, 'h400);
    read_block(3, 'h400, 6, 1'b0, 1'b0, "rst32");
    i_rd_wr_ctl = 1'b0; i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_b("mid.valid", o_valid, 1'b0);
    chk_b("mid.last", o_last, 1'b0);
    chk_r("mid.data", o_data, '0);
    chk_b("mid.ovf", o_ovf, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    write_block(1, 'h500);
    read_block(1, 'h500, 2, 1'b1, 1'b0, "post8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
